// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: steps a position counter at a
// programmable rate and drives the matching A/B phases, direction and strobe.
// Optional index pulse on Z when QUAD_ENCODER_INDEX_EN is defined; otherwise
// Z is tied low and no index logic exists.
module quad_encoder_gen #(
  parameter int unsigned POS_WIDTH = 16,
  parameter int unsigned CPR       = 1024,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 horario,
  input  logic                 antihorario,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 A,
  output logic                 B,
  output logic                 Z,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 dir,
  output logic                 step
);

  localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(CPR - 1);

  logic                 valid;
  logic                 take;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] presc_next;
  logic [POS_WIDTH-1:0] pos_next;
  logic                 a_next;
  logic                 b_next;

  // Request qualification, prescaler and next position/phase computation
  always_comb begin
    valid      = en & (horario ^ antihorario);
    take       = valid & (presc >= div);
    presc_next = '0;
    pos_next   = pos;
    if (valid && !take) begin
      presc_next = presc + DIV_WIDTH'(1);
    end
    if (take) begin
      if (horario) begin
        pos_next = (pos == POS_MAX) ? '0 : pos + POS_WIDTH'(1);
      end else begin
        pos_next = (pos == '0) ? POS_MAX : pos - POS_WIDTH'(1);
      end
    end
    // Gray mapping 0->00, 1->10, 2->11, 3->01 for {A,B}
    a_next = pos_next[1] ^ pos_next[0];
    b_next = pos_next[1];
  end

  // Position, phases, direction, strobe and prescaler registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      pos   <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      dir   <= 1'b0;
      step  <= 1'b0;
    end else begin
      presc <= presc_next;
      step  <= take;
      if (take) begin
        pos <= pos_next;
        A   <= a_next;
        B   <= b_next;
        dir <= horario;
      end
    end
  end

`ifdef QUAD_ENCODER_INDEX_EN
  // Index pulse: set on the step that enters position 0, cleared on the step that leaves it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z <= 1'b0;
    end else if (take) begin
      Z <= (pos_next == '0);
    end
  end
`else
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// behavioural model of position/phase rules.
module tb_quad_encoder_gen;

  localparam int unsigned POS_WIDTH = 8;
  localparam int unsigned CPR       = 8;
  localparam int unsigned DIV_WIDTH = 4;
`ifdef QUAD_ENCODER_INDEX_EN
  localparam bit INDEX_EN = 1'b1;
`else
  localparam bit INDEX_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 horario;
  logic                 antihorario;
  logic [DIV_WIDTH-1:0] div;
  logic                 A;
  logic                 B;
  logic                 Z;
  logic [POS_WIDTH-1:0] pos;
  logic                 dir;
  logic                 step;

  quad_encoder_gen #(
    .POS_WIDTH(POS_WIDTH),
    .CPR(CPR),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .horario(horario),
    .antihorario(antihorario),
    .div(div),
    .A(A),
    .B(B),
    .Z(Z),
    .pos(pos),
    .dir(dir),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  int m_pos;
  int m_cnt;
  bit m_dir;
  bit m_step;
  bit m_z;
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_dir = 0; m_step = 0; m_z = 0;
  endtask

  // One clock edge of the model: count valid-request cycles, step once div+1 accumulate
  task automatic model_edge();
    bit valid;
    valid  = en && (horario != antihorario);
    m_step = 0;
    if (!valid) begin
      m_cnt = 0;
    end else if (m_cnt >= int'(div)) begin
      m_step = 1;
      m_cnt  = 0;
      m_dir  = horario;
      m_pos  = horario ? (m_pos + 1) % CPR : (m_pos + CPR - 1) % CPR;
      m_z    = INDEX_EN && (m_pos == 0);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_model();
    check("m_pos",  32'(pos),    32'(m_pos));
    check("m_ab",   32'({A, B}), 32'(ab_tab[m_pos % 4]));
    check("m_z",    32'(Z),      32'(m_z));
    check("m_dir",  32'(dir),    32'(m_dir));
    check("m_step", 32'(step),   32'(m_step));
  endtask

  // Advance one rising edge, update model, sample outputs just after the edge
  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0] exp_cw [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  int hold;

  initial begin
    rst = 1'b1; en = 1'b0; horario = 1'b0; antihorario = 1'b0; div = '0;
    model_reset();
    do_reset();
    check("rst_pos",  32'(pos), 32'd0);
    check("rst_ab",   32'({A, B}), 32'd0);
    check("rst_z",    32'(Z), 32'd0);
    check("rst_dir",  32'(dir), 32'd0);
    check("rst_step", 32'(step), 32'd0);

    // Clockwise run, div=0
    en = 1'b1; div = 4'd0; horario = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cw_pos",  32'(pos), 32'(i + 1));
      check("cw_ab",   32'({A, B}), 32'(exp_cw[i]));
      check("cw_step", 32'(step), 32'd1);
    end
    check("cw_dir", 32'(dir), 32'd1);
    horario = 1'b0;
    tick();
    check("cw_idle_step", 32'(step), 32'd0);
    check("cw_idle_pos",  32'(pos), 32'd5);

    // Prescale div=3, counter-clockwise for 12 edges
    do_reset();
    en = 1'b1; div = 4'd3; antihorario = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("pre_step", 32'(step), 32'(e % 4 == 0));
      if (e % 4 == 0) check("pre_pos", 32'(pos), 32'(CPR - e / 4));
    end
    check("pre_dir", 32'(dir), 32'd0);
    antihorario = 1'b0;

    // Wrap and index, div=0, 8 clockwise steps then one back
    do_reset();
    en = 1'b1; div = 4'd0; horario = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("wrap_pos", 32'(pos), 32'(i % 8));
      check("wrap_z",   32'(Z), 32'(INDEX_EN && i == 8));
    end
    horario = 1'b0; antihorario = 1'b1;
    tick();
    check("back_pos", 32'(pos), 32'd7);
    check("back_ab",  32'({A, B}), 32'(2'b01));
    check("back_z",   32'(Z), 32'd0);

    // Invalid requests: both high, then disabled
    horario = 1'b1; antihorario = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("both_step", 32'(step), 32'd0);
      check("both_pos",  32'(pos), 32'd7);
    end
    en = 1'b0; antihorario = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis_step", 32'(step), 32'd0);
      check("dis_pos",  32'(pos), 32'd7);
      check("dis_ab",   32'({A, B}), 32'(2'b01));
    end
    // Prescaler must start from zero: with div=2 the step lands on edge 3
    en = 1'b1; div = 4'd2;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("inv_step", 32'(step), 32'(e == 3));
    end
    check("inv_pos", 32'(pos), 32'd0);
    check("inv_z",   32'(Z), 32'(INDEX_EN));
    horario = 1'b0;

    // Reset mid-operation
    do_reset();
    en = 1'b1; div = 4'd0; horario = 1'b1;
    tick(); tick();
    div = 4'd5;
    tick(); tick(); tick();
    check("mid_pre_pos", 32'(pos), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_pos",  32'(pos), 32'd0);
    check("mid_ab",   32'({A, B}), 32'd0);
    check("mid_z",    32'(Z), 32'd0);
    check("mid_dir",  32'(dir), 32'd0);
    check("mid_step", 32'(step), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("mid_first", 32'(step), 32'(e == 6));
    end
    check("mid_after_pos", 32'(pos), 32'd1);
    horario = 1'b0;

    // Randomized run against the model
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        hold        = int'($urandom_range(1, 8));
        en          = ($urandom_range(0, 7) != 0);
        horario     = 1'($urandom_range(0, 1));
        antihorario = 1'($urandom_range(0, 1));
        div         = 4'($urandom_range(0, 3));
      end
      hold--;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 The block SHALL have parameter POS_WIDTH, default 16, meaning the position counter width.
REQ-002 The block SHALL have parameter CPR, default 1024, meaning counts per revolution; legal values are multiples of 4 from 4 to 2^POS_WIDTH.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 8, meaning the step-rate divider width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: generator enable.
REQ-007 The block SHALL have port horario, input, 1 bit: clockwise step request.
REQ-008 The block SHALL have port antihorario, input, 1 bit: counter-clockwise step request.
REQ-009 The block SHALL have port div, input, DIV_WIDTH bits: a step is taken every div+1 cycles.
REQ-010 The block SHALL have ports A and B, output, 1 bit each: quadrature phases.
REQ-011 The block SHALL have port Z, output, 1 bit: index pulse.
REQ-012 The block SHALL have port pos, output, POS_WIDTH bits: current position, range 0..CPR-1.
REQ-013 The block SHALL have port dir, output, 1 bit: direction of the last step (1 = horario, 0 = antihorario).
REQ-014 The block SHALL have port step, output, 1 bit: one-cycle strobe marking a position update.

Function
REQ-015 A request SHALL be valid only when en=1 and exactly one of horario/antihorario is 1; both high or both low is no request.
REQ-016 A prescaler counter SHALL increment on each cycle with a valid request, and SHALL clear to 0 on any cycle without one.
REQ-017 A step SHALL be taken at the edge where the valid request is present and the prescaler is >= div; the prescaler then clears to 0.
  - With div=0, a step is taken every cycle.
  - With div=N, the first step is taken N+1 edges after the request rises.
  - If div is lowered below the current count, the step is taken at the next edge.
REQ-018 A direction change between consecutive valid-request cycles SHALL NOT clear the prescaler.
REQ-019 On a horario step, pos SHALL increment, wrapping from CPR-1 to 0; on an antihorario step, pos SHALL decrement, wrapping from 0 to CPR-1.
REQ-020 {A,B} SHALL be registered and SHALL track pos[1:0] in the same cycle pos updates: 0->00, 1->10, 2->11, 3->01.
  - Clockwise sequence: 00,10,11,01.
  - Counter-clockwise sequence is its reverse.
  - Exactly one phase changes per step.
REQ-021 dir SHALL update to the step direction on each step, and hold otherwise.
REQ-022 step SHALL be 1 for exactly the cycle in which the new pos, A and B first appear; otherwise 0.
REQ-023 With no step, all outputs except step SHALL hold their values.
REQ-024 Deasserting en SHALL freeze pos, A, B, Z and dir, and SHALL clear the prescaler.

Reset
REQ-025 While rst=1, the block SHALL force pos=0, A=0, B=0, Z=0, dir=0, step=0 and prescaler=0, immediately and independent of clk.
REQ-026 After rst falls, the first step SHALL require a full div+1 cycles of valid request; a reset mid-count SHALL discard the partial count.

Configuration
REQ-027 With macro QUAD_ENCODER_INDEX_EN defined, Z SHALL be a registered output equal to 1 exactly while pos==0, excluding the reset state.
  - Z rises with the step that enters pos 0.
  - Z falls with the step that leaves pos 0.
REQ-028 Without QUAD_ENCODER_INDEX_EN, Z SHALL be constant 0 and no index logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-029 Bench SHALL cover clockwise run: div=0, horario=1 for 5 cycles from reset -> {A,B}=10,11,01,00,10; pos=1,2,3,4,5; step high 5 cycles; dir=1.
REQ-030 Bench SHALL cover prescale: div=3, antihorario held 12 cycles -> exactly 3 steps, at edges 4, 8 and 12; pos=CPR-1, CPR-2, CPR-3; dir=0.
REQ-031 Bench SHALL cover wrap and index: CPR=8 with QUAD_ENCODER_INDEX_EN, div=0, horario for 8 steps from 0.
  - pos sequence: 1..7, 0.
  - Z=1 only after the 8th step.
  - One antihorario step then gives pos=7, Z=0.
REQ-032 Bench SHALL cover invalid requests: horario=antihorario=1 for 4 cycles, then en=0 with horario=1 for 4 cycles -> no step; pos, A, B unchanged; prescaler 0.
REQ-033 Bench SHALL cover reset mid-operation: div=5, horario held, rst pulsed after 3 cycles -> all outputs 0 immediately; first step 6 edges after rst falls.
REQ-034 Bench SHALL cover a macro-off build: repeat REQ-031 without the macro -> identical pos/A/B, and Z constantly 0.
